receiver_spi: RTL and testbench

SPI slave receiver that sits directly downstream of the SPI master transmitter: it consumes `CS`, `SCK` and `MOSI`, returns `MISO`, and can be daisy-chained behind another receiver. Every 16 received bits form one word, delivered to the local logic as a one-cycle strobe. All SPI inputs are oversampled and synchronised into the `clk` domain, so `SCK` is never used as a clock.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 17 +
 rtl/receiver_spi.sv | 94 +++++++++
 tb/tb_receiver_spi.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI definitions for the master and the receiver.
// Contains the default word width, the FSM state encoding and the SCK mode decode.
package spi_pkg;
    localparam int SPI_WIDTH = 16;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    function automatic logic sample_on_rise(input logic ckp, input logic cph);
        return ckp == cph;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser with an extra flop for rise/fall detection.
// Flops clear to 0 so that a line already low at reset never looks like a falling edge.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] q;
    always_ff @(posedge clk)
        q <= !rst ? 3'b000 : {q[1:0], d};
    assign level = q[1];
    assign rise  = q[1] & ~q[2];
    assign fall  = ~q[1] & q[2];
endmodule

// File: rtl/receiver_spi.sv
// receiver_spi: oversampled SPI slave receiver with daisy-chain pass-through.
// Define SPI_RX_MSB_FIRST_EN for MSB-first bit order; LSB first otherwise.
module receiver_spi
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CKP,
    input  logic             CPH,
    input  logic             CS,
    input  logic             SCK,
    input  logic             MOSI,
    input  logic [WIDTH-1:0] tx_data,
    output logic             MISO,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             abort
);
    localparam int CW = $clog2(WIDTH);
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] sh, sh_next;
    logic [1:0] mosi_q;
    logic mosi_s, sh_out, tx_out, last;
    logic sck_lvl, sck_rise, sck_fall, sck_edge, sample, shift;
    logic cs_lvl, cs_rise, cs_fall;

    spi_sync_edge u_sck (.clk(clk), .rst(rst), .d(SCK), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge u_cs (.clk(clk), .rst(rst), .d(CS), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

    assign mosi_s   = mosi_q[1];
    assign sck_edge = sck_rise | sck_fall;
    assign sample   = sck_edge & (sck_lvl == sample_on_rise(CKP, CPH));
    assign shift    = sck_edge & (sck_lvl != sample_on_rise(CKP, CPH));
    assign last     = cnt == CW'(WIDTH - 1);
    assign busy     = state != IDLE;

`ifdef SPI_RX_MSB_FIRST_EN
    assign sh_next = {sh[WIDTH-2:0], mosi_s};
    assign sh_out  = sh[WIDTH-1];
    assign tx_out  = tx_data[WIDTH-1];
`else
    assign sh_next = {mosi_s, sh[WIDTH-1:1]};
    assign sh_out  = sh[0];
    assign tx_out  = tx_data[0];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            mosi_q   <= '0;
            MISO     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            abort    <= 1'b0;
        end else begin
            mosi_q   <= {mosi_q[0], MOSI};
            rx_valid <= 1'b0;
            abort    <= 1'b0;
            case (state)
                IDLE: if (cs_fall) state <= LOAD;
                LOAD: begin
                    sh    <= tx_data;
                    cnt   <= '0;
                    MISO  <= cs_lvl ? 1'b0 : tx_out;
                    state <= cs_lvl ? IDLE : SHIFT;
                end
                SHIFT:
                    // a CS rise masks any sample edge detected in the same cycle
                    if (cs_rise) begin
                        state <= IDLE;
                        abort <= cnt != '0;
                        cnt   <= '0;
                        MISO  <= 1'b0;
                    end else if (sample) begin
                        sh  <= sh_next;
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last) begin
                            rx_data  <= sh_next;
                            rx_valid <= 1'b1;
                        end
                    end else if (shift) begin
                        MISO <= sh_out;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_receiver_spi.sv
// tb_receiver_spi: randomized SPI master driving receiver_spi in all four modes.
// Expected words and MISO streams come from a bit-stream model of the link.
module tb_receiver_spi;
    localparam int W = 16;
`ifdef SPI_RX_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, ckp = 1'b0, cph = 1'b0, cs = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic miso, rx_valid, busy, abort;
    logic [W-1:0] rx_data;
    int n_cmp = 0, n_err = 0, n_valid = 0, n_abort = 0, half = 5;
    logic [W-1:0] got[$];
    logic [W-1:0] words[4];
    logic [63:0] miso_st;

    always #5 clk = ~clk;

    receiver_spi #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .CKP(ckp), .CPH(cph), .CS(cs), .SCK(sck), .MOSI(mosi),
        .tx_data(tx_data), .MISO(miso), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .abort(abort)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            got.push_back(rx_data);
        end
        if (abort) n_abort++;
    end

    function automatic logic word_bit(input logic [W-1:0] w, input int i);
        return MSB ? w[W-1-i] : w[i];
    endfunction

    function automatic logic mosi_bit(input int i);
        return word_bit(words[i/W], i % W);
    endfunction

    // first word out is tx_data, after that the receiver echoes MOSI delayed by one word
    function automatic logic exp_miso(input logic [W-1:0] tx, input int i);
        return i < W ? word_bit(tx, i) : mosi_bit(i - W);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input int m);
        cyc(1);
        ckp = m[1];
        cph = m[0];
        sck = ckp;
        cyc(8);
    endtask

    task automatic clock_bits(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            if (!cph) begin
                mosi = mosi_bit(i);
                cyc(half);
                miso_st[i] = miso;
                sck = ~sck;
                cyc(half);
                sck = ~sck;
            end else begin
                sck = ~sck;
                mosi = mosi_bit(i);
                cyc(half);
                miso_st[i] = miso;
                sck = ~sck;
                cyc(half);
            end
        end
    endtask

    task automatic xfer(input logic [W-1:0] tx, input int nw);
        int v0, a0;
        logic [63:0] e, o;
        v0 = n_valid;
        a0 = n_abort;
        got.delete();
        miso_st = '0;
        tx_data = tx;
        half = $urandom_range(5, 7);
        cyc(1);
        cs = 1'b0;
        cyc(8);
        check("busy_active", 64'(busy), 64'd1);
        clock_bits(0, nw * W);
        cyc(half);
        cs = 1'b1;
        cyc(8);
        check("valid_count", 64'(n_valid - v0), 64'(nw));
        for (int k = 0; k < nw; k++)
            check("rx_word", k < got.size() ? 64'(got[k]) : 64'hx, 64'(words[k]));
        e = '0;
        o = '0;
        for (int i = 0; i < nw * W; i++) begin
            e[i] = exp_miso(tx, i);
            o[i] = miso_st[i];
        end
        check("miso_stream", o, e);
        check("rx_data_hold", 64'(rx_data), 64'(words[nw-1]));
        check("no_abort", 64'(n_abort - a0), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int v0, a0;
        logic [W-1:0] hold;
        cyc(4);
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_rx_data", 64'(rx_data), 64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_abort", 64'(abort), 64'd0);
        rst = 1'b1;
        cyc(8);

        set_mode(0);
        words[0] = 16'h1234;
        xfer(16'hA5C3, 1);
        for (int m = 1; m < 4; m++) begin
            set_mode(m);
            words[0] = 16'h0F0F;
            xfer(16'hBEEF, 1);
        end
        for (int m = 0; m < 4; m++) begin
            set_mode(m);
            words[0] = W'($urandom);
            words[1] = W'($urandom);
            xfer(W'($urandom), 2);
        end

        set_mode(0);
        words[0] = W'($urandom);
        hold = rx_data;
        v0 = n_valid;
        a0 = n_abort;
        tx_data = W'($urandom);
        cyc(1);
        cs = 1'b0;
        cyc(8);
        clock_bits(0, 7);
        cyc(half);
        cs = 1'b1;
        cyc(8);
        check("abort_count", 64'(n_abort - a0), 64'd1);
        check("abort_no_valid", 64'(n_valid - v0), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rx_hold", 64'(rx_data), 64'(hold));

        set_mode(3);
        words[0] = W'($urandom);
        v0 = n_valid;
        a0 = n_abort;
        tx_data = W'($urandom);
        cyc(1);
        cs = 1'b0;
        cyc(8);
        clock_bits(0, 9);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("mid_rst_miso", 64'(miso), 64'd0);
        check("mid_rst_rx_data", 64'(rx_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(rx_valid), 64'd0);
        check("mid_rst_abort", 64'(abort), 64'd0);
        rst = 1'b1;
        clock_bits(9, 7);
        cyc(8);
        check("after_rst_no_valid", 64'(n_valid - v0), 64'd0);
        check("after_rst_busy", 64'(busy), 64'd0);
        check("after_rst_miso", 64'(miso), 64'd0);
        cs = 1'b1;
        cyc(8);
        check("after_rst_no_abort", 64'(n_abort - a0), 64'd0);
        check("after_rst_rx_data", 64'(rx_data), 64'd0);
        words[0] = W'($urandom);
        xfer(W'($urandom), 1);

        set_mode(1);
        for (int k = 0; k < 3; k++) words[k] = W'($urandom);
        xfer(W'($urandom), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
